// File: rtl/pwm_capture.sv
// Four-channel PWM capture: each channel measures period and high time between rising
// edges, flags stuck inputs, and one read port returns a channel's latched result.
module pwm_capture #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] TIMEOUT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       pwm_in,
    input  logic [1:0]       ch_sel,
    input  logic             rd,
    output logic             rd_ack,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic [3:0]       valid,
    output logic [3:0]       overrun,
    output logic [3:0]       stuck
);
    localparam int unsigned NCH = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    logic [NCH-1:0]   sync_q;
    logic [NCH-1:0]   s_q;
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   rise;
    logic [WIDTH-1:0] lat_period [NCH];
    logic [WIDTH-1:0] lat_high   [NCH];

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            s_q    <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= pwm_in;
            s_q    <= sync_q;
            prev_q <= s_q;
        end
    end

    assign rise = s_q & ~prev_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t           state_q;
            logic [WIDTH-1:0] cnt_p_q;
            logic [WIDTH-1:0] cnt_h_q;
            logic [WIDTH-1:0] period_q;
            logic [WIDTH-1:0] high_q;
            logic             valid_q;
            logic             overrun_q;
            logic             stuck_q;
            logic             rd_hit;
            logic             timeout;
            logic             latch;

            assign rd_hit  = rd && (ch_sel == 2'(gi));
            assign timeout = !rise[gi] && (cnt_p_q == TIMEOUT) && !stuck_q;
            assign latch   = (rise[gi] && (state_q == ST_MEASURE)) || timeout;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q   <= ST_IDLE;
                    cnt_p_q   <= '0;
                    cnt_h_q   <= '0;
                    period_q  <= '0;
                    high_q    <= '0;
                    valid_q   <= 1'b0;
                    overrun_q <= 1'b0;
                    stuck_q   <= 1'b0;
                end else begin
                    if (rise[gi]) begin
                        if (state_q == ST_MEASURE) begin
                            period_q <= cnt_p_q;
                            high_q   <= cnt_h_q;
                        end
                        state_q <= ST_MEASURE;
                        cnt_p_q <= WIDTH'(1);
                        cnt_h_q <= WIDTH'(1);
                        stuck_q <= 1'b0;
                    end else if (timeout) begin
                        period_q <= '0;
                        high_q   <= s_q[gi] ? {WIDTH{1'b1}} : '0;
                        stuck_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (cnt_p_q != TIMEOUT) begin
                        // Once at TIMEOUT the counters park until the next rise.
                        cnt_p_q <= cnt_p_q + WIDTH'(1);
                        cnt_h_q <= cnt_h_q + WIDTH'(s_q[gi]);
                    end

                    // A latch landing on the same edge as a read of this channel
                    // leaves a fresh, unread result with no overrun.
                    if (latch) begin
                        valid_q   <= 1'b1;
                        overrun_q <= rd_hit ? 1'b0 : (overrun_q | valid_q);
                    end else if (rd_hit) begin
                        valid_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
            end

            assign lat_period[gi] = period_q;
            assign lat_high[gi]   = high_q;
            assign valid[gi]      = valid_q;
            assign overrun[gi]    = overrun_q;
            assign stuck[gi]      = stuck_q;
        end
    endgenerate

    // Read port samples the latches before this edge's updates land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ack    <= 1'b0;
            high_time <= '0;
            period    <= '0;
        end else begin
            rd_ack <= rd;
            if (rd) begin
                high_time <= lat_high[ch_sel];
                period    <= lat_period[ch_sel];
            end
        end
    end

endmodule
